// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Two-port arbiter for one VRAM. Video fetches have priority, but
//            the CPU is guaranteed a grant after MAX_VID_BURST consecutive video
//            grants made while it was waiting. Every access takes at least three
//            cycles (IDLE -> ACCESS -> DONE). An access that sees no
//            mem_complete_i within TIMEOUT cycles is aborted: 8'hFF is returned
//            and the sticky err_o flag is raised.
// Ports    :
//   clk, rst                    clock, asynchronous active-high reset
//   vid_req_i, vid_addr_i       video read request and address
//   vid_data_o, vid_ack_o       video read data and completion pulse
//   cpu_req_i, cpu_rw_i         CPU request, direction (1 = read, 0 = write)
//   cpu_addr_i, cpu_di_i        CPU address and write data
//   cpu_do_o, cpu_ack_o         CPU read data and completion pulse
//   mem_addr_o, mem_do_o        VRAM address and write data
//   mem_we_o, mem_cs_o          VRAM write enable and access strobe
//   mem_di_i, mem_complete_i    VRAM read data and completion
//   busy_o                      high whenever the FSM is not idle
//   err_o, err_clr_i            sticky timeout flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int MAX_VID_BURST = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req_i,
  input  logic [15:0] vid_addr_i,
  output logic [7:0]  vid_data_o,
  output logic        vid_ack_o,
  input  logic        cpu_req_i,
  input  logic        cpu_rw_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_di_i,
  output logic [7:0]  cpu_do_o,
  output logic        cpu_ack_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_do_o,
  output logic        mem_we_o,
  output logic        mem_cs_o,
  input  logic [7:0]  mem_di_i,
  input  logic        mem_complete_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_VID_BURST);
  localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        cs_q, cs_d;
  logic        owner_cpu_q, owner_cpu_d;   // 1 = current access belongs to CPU
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic [7:0]  cpu_do_q, cpu_do_d;
  logic        err_q, err_d;

  logic        w_any_req;
  logic        w_grant_cpu;
  logic [7:0]  w_wait_inc;

  assign w_any_req   = vid_req_i | cpu_req_i;
  // CPU wins when it is alone, or when video has used up its burst allowance.
  assign w_grant_cpu = cpu_req_i & (~vid_req_i | (streak_q == C_MAX_BURST));
  assign w_wait_inc  = wait_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      cs_q        <= 1'b0;
      owner_cpu_q <= 1'b0;
      streak_q    <= 4'd0;
      wait_q      <= 8'd0;
      vid_data_q  <= 8'h00;
      cpu_do_q    <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cs_q        <= cs_d;
      owner_cpu_q <= owner_cpu_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      vid_data_q  <= vid_data_d;
      cpu_do_q    <= cpu_do_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cs_d        = cs_q;
    owner_cpu_d = owner_cpu_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    vid_data_d  = vid_data_q;
    cpu_do_d    = cpu_do_q;
    err_d       = err_q;

    // Clear first so that a timeout in the same cycle overrides it below.
    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          state_d     = ST_ACCESS;
          cs_d        = 1'b1;
          wait_d      = 8'd0;
          owner_cpu_d = w_grant_cpu;
          if (w_grant_cpu) begin
            addr_d   = cpu_addr_i;
            wdata_d  = cpu_di_i;
            we_d     = ~cpu_rw_i;
            streak_d = 4'd0;
          end else begin
            addr_d  = vid_addr_i;
            wdata_d = 8'h00;
            we_d    = 1'b0;
            // Only video grants that make the CPU wait count toward the burst.
            if (cpu_req_i) begin
              streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
            end else begin
              streak_d = 4'd0;
            end
          end
        end else begin
          streak_d = 4'd0;
        end
      end

      ST_ACCESS: begin
        if (mem_complete_i) begin
          cs_d    = 1'b0;
          state_d = ST_DONE;
          if (owner_cpu_q) begin
            if (!we_q) begin
              cpu_do_d = mem_di_i;
            end
          end else begin
            vid_data_d = mem_di_i;
          end
        end else if (w_wait_inc == C_TIMEOUT) begin
          cs_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (owner_cpu_q) begin
            cpu_do_d = 8'hFF;
          end else begin
            vid_data_d = 8'hFF;
          end
        end else begin
          wait_d = w_wait_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  // Acks decode straight from registered state: one DONE cycle, one owner.
  assign vid_ack_o  = (state_q == ST_DONE) & ~owner_cpu_q;
  assign cpu_ack_o  = (state_q == ST_DONE) &  owner_cpu_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign mem_addr_o = addr_q;
  assign mem_do_o   = wdata_q;
  assign mem_we_o   = we_q;
  assign mem_cs_o   = cs_q;
  assign vid_data_o = vid_data_q;
  assign cpu_do_o   = cpu_do_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: MAX_VID_BURST, default 4; the maximum number of consecutive video grants while a CPU request is pending (range 1..15).
REQ-002 Parameter: TIMEOUT, default 15; the number of cycles an access may wait for mem_complete before it is aborted (range 1..255).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 vid_req  in  1  video fetch request; held high until vid_ack.
REQ-006 vid_addr  in  16  video fetch address.
REQ-007 vid_data  out  8  video read data; valid while vid_ack is high and held until the next video completion.
REQ-008 vid_ack  out  1  single-cycle video completion pulse.
REQ-009 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-010 cpu_rw  in  1  CPU direction: 1 = read, 0 = write.
REQ-011 cpu_addr  in  16  CPU address.
REQ-012 cpu_di  in  8  CPU write data.
REQ-013 cpu_do  out  8  CPU read data; valid while cpu_ack is high and held until the next CPU read completion.
REQ-014 cpu_ack  out  1  single-cycle CPU completion pulse.
REQ-015 mem_addr  out  16  VRAM address.
REQ-016 mem_do  out  8  VRAM write data.
REQ-017 mem_we  out  1  VRAM write enable; valid while mem_cs is high.
REQ-018 mem_cs  out  1  VRAM access strobe.
REQ-019 mem_di  in  8  VRAM read data.
REQ-020 mem_complete  in  1  VRAM done; mem_di is valid in the same cycle.
REQ-021 busy  out  1  high whenever the state is not IDLE.
REQ-022 err  out  1  sticky timeout flag.
REQ-023 err_clr  in  1  clears err.

Function
REQ-024 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-025 IDLE: when any request is high, the block SHALL latch the winner's address, data and rw, set mem_cs=1, and move to ACCESS on the same edge.
REQ-026 Arbitration: video SHALL win unless cpu_req=1 and streak==MAX_VID_BURST, in which case the CPU SHALL win.
REQ-027 streak is a 4-bit counter: +1 (saturating) on each video grant made while cpu_req=1; cleared on a CPU grant; cleared in any IDLE cycle where cpu_req=0.
REQ-028 mem_addr, mem_do and mem_we SHALL be driven from registers latched at the grant and SHALL be stable for the whole of ACCESS.
REQ-029 mem_we SHALL be 1 only for a CPU write; a video access SHALL always be a read.
REQ-030 ACCESS: when mem_complete=1, the block SHALL clear mem_cs, capture mem_di into vid_data or cpu_do (CPU reads only), and move to DONE.
REQ-031 ACCESS timeout: an 8-bit wait counter SHALL reset at the grant; when it reaches TIMEOUT without mem_complete, the block SHALL clear mem_cs, set err=1, load 8'hFF into the winner's read-data register, and move to DONE.
REQ-032 DONE: the block SHALL assert the winner's ack for exactly one cycle, then return to IDLE; requests SHALL NOT be sampled in DONE.
REQ-033 Requesters SHALL drop their request on the edge after ack is seen; minimum transaction length is 3 cycles (IDLE, ACCESS, DONE).
REQ-034 mem_complete arriving in IDLE or DONE SHALL be ignored.
REQ-035 A request withdrawn during ACCESS SHALL NOT abort the access; the access completes and ack is still pulsed.
REQ-036 If err_clr and a new timeout occur in the same cycle, err SHALL end the cycle at 1 (set wins).
REQ-037 vid_ack and cpu_ack SHALL never be high in the same cycle.

Reset
REQ-038 Asserting rst SHALL immediately force: state=IDLE; mem_cs, mem_we, vid_ack, cpu_ack, busy and err to 0; mem_addr, mem_do, vid_data and cpu_do to 0; streak and the wait counter to 0.
REQ-039 Reset during ACCESS SHALL abandon the access without issuing an ack; the next grant follows normal arbitration after rst falls.

Verification
REQ-040 Video read: vid_req, vid_addr=16'h1234, mem_di=8'hA5 with mem_complete 2 cycles after mem_cs -> mem_addr=16'h1234, mem_we=0, then one vid_ack pulse with vid_data=8'hA5.
REQ-041 CPU write: cpu_req, cpu_rw=0, cpu_addr=16'h8000, cpu_di=8'h3C -> mem_we=1 and mem_do=8'h3C during ACCESS, then one cpu_ack pulse; cpu_do unchanged.
REQ-042 Fairness: vid_req and cpu_req both held continuously, MAX_VID_BURST=4 -> grant order V,V,V,V,C,V,V,V,V,C.
REQ-043 Timeout: mem_complete held at 0, TIMEOUT=15 -> mem_cs falls 15 cycles after the grant, err=1, ack pulses with read data 8'hFF; err_clr -> err=0.
REQ-044 Reset mid-ACCESS: rst asserted 1 cycle into ACCESS -> mem_cs=0 asynchronously, no ack pulse, busy=0.
REQ-045 Stray mem_complete in IDLE -> no ack pulse and no change to the read-data registers.
